// File: rtl/jamma_input_scanner.sv
// JAMMA splitter scanner: drives JSELECT, samples both player banks, debounces and stretches coins.
// Optional macro JAMMA_SOCD_CLEAN_EN neutralises opposing directions on the joystick outputs.
module jamma_input_scanner #(
  parameter int unsigned SETTLE_CYCLES   = 16,
  parameter int unsigned DEBOUNCE_FRAMES = 4,
  parameter int unsigned COIN_STRETCH    = 8
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] JJOY,
  input  logic [5:0] JOYSTICK,
  input  logic [1:0] JCOIN,
  output logic       JSELECT,
  output logic [7:0] joystick1,
  output logic [7:0] joystick2,
  output logic [1:0] coin,
  output logic       frame_tick
);

  localparam int unsigned SW = (SETTLE_CYCLES   > 1) ? $clog2(SETTLE_CYCLES + 1)   : 1;
  localparam int unsigned DW = (DEBOUNCE_FRAMES > 1) ? $clog2(DEBOUNCE_FRAMES + 1) : 1;
  localparam int unsigned CW = $clog2(COIN_STRETCH + 1);
  localparam int unsigned NB = 18;

  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
  localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_FRAMES - 1);
  localparam logic [CW-1:0] STRETCH_LD  = CW'(COIN_STRETCH);

  typedef enum logic [2:0] {SEL_A, SAMP_A, SEL_B, SAMP_B, PUBLISH} state_t;

  state_t          state;
  logic [SW-1:0]   settle_cnt;
  // raw/stable layout: [7:0] player 1, [15:8] player 2, [17:16] coins
  logic [NB-1:0]   raw;
  logic [NB-1:0]   stable;
  logic [DW-1:0]   dcnt     [NB];
  logic [CW-1:0]   scnt     [2];

  logic [NB-1:0]   db_nxt;
  logic [DW-1:0]   dcnt_nxt [NB];
  logic [CW-1:0]   scnt_nxt [2];
  logic [1:0]      coin_nxt;
  logic [7:0]      j1_nxt;
  logic [7:0]      j2_nxt;

`ifdef JAMMA_SOCD_CLEAN_EN
  function automatic logic [7:0] socd_clean(input logic [7:0] j);
    logic [7:0] r;
    r = j;
    if (!j[0] && !j[1]) r[1:0] = 2'b11;
    if (!j[2] && !j[3]) r[3:2] = 2'b11;
    return r;
  endfunction
`endif

  always_comb begin
    for (int unsigned i = 0; i < NB; i++) begin
      db_nxt[i]   = stable[i];
      dcnt_nxt[i] = dcnt[i];
      if (raw[i] == stable[i]) begin
        dcnt_nxt[i] = '0;
      end else if (dcnt[i] >= DB_LAST) begin
        db_nxt[i]   = raw[i];
        dcnt_nxt[i] = '0;
      end else begin
        dcnt_nxt[i] = dcnt[i] + DW'(1);
      end
    end

    // Output uses the post-decrement count, so a press reads low for exactly COIN_STRETCH frames.
    for (int unsigned n = 0; n < 2; n++) begin
      scnt_nxt[n] = scnt[n];
      coin_nxt[n] = db_nxt[16+n];
      if (scnt[n] == '0) begin
        if (stable[16+n] && !db_nxt[16+n]) begin
          scnt_nxt[n] = STRETCH_LD;
          coin_nxt[n] = 1'b0;
        end
      end else begin
        scnt_nxt[n] = scnt[n] - CW'(1);
        if (scnt_nxt[n] != '0) coin_nxt[n] = 1'b0;
      end
    end

`ifdef JAMMA_SOCD_CLEAN_EN
    j1_nxt = socd_clean(db_nxt[7:0]);
    j2_nxt = socd_clean(db_nxt[15:8]);
`else
    j1_nxt = db_nxt[7:0];
    j2_nxt = db_nxt[15:8];
`endif
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= SEL_A;
      settle_cnt <= SETTLE_LOAD;
      JSELECT    <= 1'b0;
      raw        <= '1;
      stable     <= '1;
      for (int unsigned i = 0; i < NB; i++) dcnt[i] <= '0;
      for (int unsigned n = 0; n < 2; n++)  scnt[n] <= '0;
      joystick1  <= '1;
      joystick2  <= '1;
      coin       <= '1;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      case (state)
        SEL_A: begin
          if (settle_cnt == '0) state <= SAMP_A;
          else settle_cnt <= settle_cnt - SW'(1);
        end
        SAMP_A: begin
          raw[7:0]   <= JJOY & {2'b11, JOYSTICK};
          raw[17:16] <= JCOIN;
          settle_cnt <= SETTLE_LOAD;
          JSELECT    <= 1'b1;
          state      <= SEL_B;
        end
        SEL_B: begin
          if (settle_cnt == '0) state <= SAMP_B;
          else settle_cnt <= settle_cnt - SW'(1);
        end
        SAMP_B: begin
          raw[15:8] <= JJOY;
          JSELECT   <= 1'b0;
          state     <= PUBLISH;
        end
        PUBLISH: begin
          stable     <= db_nxt;
          dcnt       <= dcnt_nxt;
          scnt       <= scnt_nxt;
          joystick1  <= j1_nxt;
          joystick2  <= j2_nxt;
          coin       <= coin_nxt;
          frame_tick <= 1'b1;
          settle_cnt <= SETTLE_LOAD;
          state      <= SEL_A;
        end
        default: begin
          state      <= SEL_A;
          settle_cnt <= SETTLE_LOAD;
          JSELECT    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jamma_input_scanner.sv
// Scoreboard bench for jamma_input_scanner: per-frame directed vectors, monitor checks on frame_tick.
module tb_jamma_input_scanner;

`ifdef JAMMA_SOCD_CLEAN_EN
  localparam bit SOCD = 1'b1;
`else
  localparam bit SOCD = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [7:0] p1 = 8'hFF;
  logic [7:0] p2 = 8'hFF;
  logic [7:0] JJOY;
  logic [5:0] JOYSTICK = 6'h3F;
  logic [1:0] JCOIN = 2'b11;
  logic       JSELECT;
  logic [7:0] joystick1;
  logic [7:0] joystick2;
  logic [1:0] coin;
  logic       frame_tick;

  // splitter model: the bank presented follows JSELECT
  assign JJOY = JSELECT ? p2 : p1;

  jamma_input_scanner #(
    .SETTLE_CYCLES  (16),
    .DEBOUNCE_FRAMES(4),
    .COIN_STRETCH   (8)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .JJOY      (JJOY),
    .JOYSTICK  (JOYSTICK),
    .JCOIN     (JCOIN),
    .JSELECT   (JSELECT),
    .joystick1 (joystick1),
    .joystick2 (joystick2),
    .coin      (coin),
    .frame_tick(frame_tick)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [7:0] j1;
    logic [7:0] j2;
    logic [1:0] c;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (frame_tick) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_tick: got tick expected none at %0t", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("joystick1", {24'h0, joystick1}, {24'h0, e.j1});
        check("joystick2", {24'h0, joystick2}, {24'h0, e.j2});
        check("coin",      {30'h0, coin},      {30'h0, e.c});
      end
    end
  end

  task automatic wait_tick();
    int k;
    k = 0;
    do begin
      @(negedge CLK);
      k++;
    end while (!frame_tick && k < 200);
    if (!frame_tick) begin
      n_tests++;
      n_fail++;
      $display("FAIL tick_timeout: got no tick expected one within 200 cycles");
    end
  endtask

  task automatic run(input int n, input logic [7:0] a, input logic [7:0] b,
                     input logic [5:0] j, input logic [1:0] c,
                     input logic [7:0] e1, input logic [7:0] e2, input logic [1:0] ec);
    for (int i = 0; i < n; i++) begin
      p1       = a;
      p2       = b;
      JOYSTICK = j;
      JCOIN    = c;
      sb.push_back('{j1: e1, j2: e2, c: ec});
      wait_tick();
    end
  endtask

  initial begin
    logic [7:0] s1;
    logic [7:0] s2;
    s1 = SOCD ? 8'hFF : 8'hFC;
    s2 = SOCD ? 8'hFF : 8'hF3;

    RESET = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    // this negedge is frame cycle 0
    check("rst_j1",   {24'h0, joystick1}, 32'hFF);
    check("rst_j2",   {24'h0, joystick2}, 32'hFF);
    check("rst_coin", {30'h0, coin},      32'h3);
    sb.push_back('{j1: 8'hFF, j2: 8'hFF, c: 2'b11});
    for (int c = 0; c < 35; c++) begin
      check($sformatf("jselect_c%0d", c), {31'h0, JSELECT}, (c >= 17 && c <= 33) ? 32'h1 : 32'h0);
      check($sformatf("tick_c%0d", c), {31'h0, frame_tick}, 32'h0);
      @(negedge CLK);
    end
    check("tick_c35",    {31'h0, frame_tick}, 32'h1);
    check("jselect_c35", {31'h0, JSELECT},    32'h0);

    // bank demux
    run(3, 8'hFE, 8'hFD, 6'h3F, 2'b11, 8'hFF, 8'hFF, 2'b11);
    run(1, 8'hFE, 8'hFD, 6'h3F, 2'b11, 8'hFE, 8'hFD, 2'b11);
    run(3, 8'hFF, 8'hFF, 6'h3F, 2'b11, 8'hFE, 8'hFD, 2'b11);
    run(1, 8'hFF, 8'hFF, 6'h3F, 2'b11, 8'hFF, 8'hFF, 2'b11);

    // glitch rejection on fire1
    run(3, 8'hEF, 8'hFF, 6'h3F, 2'b11, 8'hFF, 8'hFF, 2'b11);
    run(1, 8'hFF, 8'hFF, 6'h3F, 2'b11, 8'hFF, 8'hFF, 2'b11);
    run(3, 8'hEF, 8'hFF, 6'h3F, 2'b11, 8'hFF, 8'hFF, 2'b11);
    run(1, 8'hFF, 8'hFF, 6'h3F, 2'b11, 8'hFF, 8'hFF, 2'b11);

    // DB9 merge into player 1
    run(3, 8'hFF, 8'hFF, 6'h3B, 2'b11, 8'hFF, 8'hFF, 2'b11);
    run(1, 8'hFF, 8'hFF, 6'h3B, 2'b11, 8'hFB, 8'hFF, 2'b11);
    run(3, 8'hFF, 8'hFF, 6'h3F, 2'b11, 8'hFB, 8'hFF, 2'b11);
    run(1, 8'hFF, 8'hFF, 6'h3F, 2'b11, 8'hFF, 8'hFF, 2'b11);

    // coin 0: 5 frames low, stretched output low for frames 4..11
    run(3, 8'hFF, 8'hFF, 6'h3F, 2'b10, 8'hFF, 8'hFF, 2'b11);
    run(2, 8'hFF, 8'hFF, 6'h3F, 2'b10, 8'hFF, 8'hFF, 2'b10);
    run(6, 8'hFF, 8'hFF, 6'h3F, 2'b11, 8'hFF, 8'hFF, 2'b10);
    run(2, 8'hFF, 8'hFF, 6'h3F, 2'b11, 8'hFF, 8'hFF, 2'b11);

    // SOCD on player 2 left+right
    run(3, 8'hFF, 8'hF3, 6'h3F, 2'b11, 8'hFF, 8'hFF, 2'b11);
    run(1, 8'hFF, 8'hF3, 6'h3F, 2'b11, 8'hFF, s2,    2'b11);
    run(3, 8'hFF, 8'hFF, 6'h3F, 2'b11, 8'hFF, s2,    2'b11);
    run(1, 8'hFF, 8'hFF, 6'h3F, 2'b11, 8'hFF, 8'hFF, 2'b11);

    // SOCD on player 1 up+down
    run(3, 8'hFC, 8'hFF, 6'h3F, 2'b11, 8'hFF, 8'hFF, 2'b11);
    run(1, 8'hFC, 8'hFF, 6'h3F, 2'b11, s1,    8'hFF, 2'b11);

    // mid-frame reset while JSELECT is high
    repeat (20) @(negedge CLK);
    check("mid_jselect_pre", {31'h0, JSELECT}, 32'h1);
    RESET = 1'b1;
    p1    = 8'hFF;
    @(negedge CLK);
    check("mid_rst_j1",      {24'h0, joystick1}, 32'hFF);
    check("mid_rst_j2",      {24'h0, joystick2}, 32'hFF);
    check("mid_rst_coin",    {30'h0, coin},      32'h3);
    check("mid_rst_jselect", {31'h0, JSELECT},   32'h0);
    check("mid_rst_tick",    {31'h0, frame_tick}, 32'h0);
    @(negedge CLK);
    RESET = 1'b0;
    run(2, 8'hFF, 8'hFF, 6'h3F, 2'b11, 8'hFF, 8'hFF, 2'b11);

    repeat (3) @(negedge CLK);
    check("scoreboard_empty", sb.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
